// File: rtl/lvds_pkg.sv
// Shared constants and lane-word composition for the LVDS transmit packer.
package lvds_pkg;

  localparam int unsigned SLOTS = 7;
  localparam logic [6:0] CLK_PATTERN_DEF = 7'b1100011;

  typedef enum logic {
    MAP_VESA  = 1'b0,
    MAP_JEIDA = 1'b1
  } map_e;

  // Colours arrive zero-extended to 8 bits; for 18-bit use, only [5:0] matter.
  // JEIDA moves the six MSBs onto lanes 0..2 and the two LSBs onto lane 3.
  function automatic logic [6:0] lane_word(
    input int unsigned ch,
    input logic        hs,
    input logic        vs,
    input logic        de,
    input logic [7:0]  r,
    input logic [7:0]  g,
    input logic [7:0]  b,
    input logic        jeida
  );
    logic [5:0] rr, gg, bb;
    logic [6:0] w;
    rr = jeida ? r[7:2] : r[5:0];
    gg = jeida ? g[7:2] : g[5:0];
    bb = jeida ? b[7:2] : b[5:0];
    case (ch)
      0:       w = {rr[0], rr[1], rr[2], rr[3], rr[4], rr[5], gg[0]};
      1:       w = {gg[1], gg[2], gg[3], gg[4], gg[5], bb[0], bb[1]};
      2:       w = {bb[2], bb[3], bb[4], bb[5], hs, vs, de};
      default: w = jeida ? {r[0], r[1], g[0], g[1], b[0], b[1], 1'b0}
                         : {r[6], r[7], g[6], g[7], b[6], b[7], 1'b0};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lvds_word_map.sv
// Combinational mapping of one pixel word onto CHANNELS 7-bit lane words.
module lvds_word_map
  import lvds_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int COLOR_BITS = 6,
  parameter int MAPPING    = 0
) (
  input  logic                     hs_i,
  input  logic                     vs_i,
  input  logic                     de_i,
  input  logic [COLOR_BITS-1:0]    r_i,
  input  logic [COLOR_BITS-1:0]    g_i,
  input  logic [COLOR_BITS-1:0]    b_i,
  output logic [CHANNELS-1:0][6:0] lanes_o
);

  localparam logic JEIDA = (COLOR_BITS == 8) && (MAPPING == int'(MAP_JEIDA));

  logic [7:0] r8, g8, b8;

  assign r8 = 8'(r_i);
  assign g8 = 8'(g_i);
  assign b8 = 8'(b_i);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign lanes_o[i] = lane_word(i, hs_i, vs_i, de_i, r8, g8, b8, JEIDA);
  end

endmodule

// File: rtl/lvds_tx_packer.sv
// LVDS transmit packer: 2-entry pixel buffer, 7-slot serialiser per lane and
// forwarded-clock lane, blanking insertion on underflow.
module lvds_tx_packer
  import lvds_pkg::*;
#(
  parameter int         CHANNELS    = 3,
  parameter int         COLOR_BITS  = 6,
  parameter int         MAPPING     = 0,
  parameter logic [6:0] CLK_PATTERN = CLK_PATTERN_DEF,
  parameter int         CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic                  in_de,
  input  logic [COLOR_BITS-1:0] in_red,
  input  logic [COLOR_BITS-1:0] in_green,
  input  logic [COLOR_BITS-1:0] in_blue,
  output logic [CHANNELS-1:0]   out_data,
  output logic                  out_clk,
  output logic                  word_start,
  output logic                  underflow,
  output logic [CNT_W-1:0]      underflow_count
);

  if (!(((COLOR_BITS == 6) && (CHANNELS == 3)) ||
        ((COLOR_BITS == 8) && (CHANNELS == 4))) ||
      (MAPPING < 0) || (MAPPING > 1) || (CNT_W < 1)) begin : g_bad_params
    $error("lvds_tx_packer: illegal CHANNELS/COLOR_BITS/MAPPING/CNT_W combination");
  end

  localparam int          CB        = COLOR_BITS;
  localparam int          PW        = 3 + 3 * CB;
  localparam logic [2:0]  LAST_SLOT = 3'(SLOTS - 1);

  logic [PW-1:0]              buf_q [2];
  logic                       wr_ptr_q, rd_ptr_q;
  logic [1:0]                 count_q;
  logic [2:0]                 slot_q;
  logic [CHANNELS-1:0][6:0]   sh_q;
  logic [6:0]                 clk_sh_q;
  logic                       word_start_q, underflow_q;
  logic [CNT_W-1:0]           uf_cnt_q;
  logic                       last_hs_q, last_vs_q;

  logic                       load, empty, push, pop;
  logic [PW-1:0]              head;
  logic                       map_hs, map_vs, map_de;
  logic [CB-1:0]              map_r, map_g, map_b;
  logic [CHANNELS-1:0][6:0]   lanes;

  assign load     = (slot_q == LAST_SLOT);
  assign empty    = (count_q == 2'd0);
  assign in_ready = (count_q < 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = load && enable && !empty;
  assign head     = buf_q[rd_ptr_q];

  // An empty buffer substitutes a blanking word that repeats the last sync state.
  always_comb begin
    map_hs = empty ? last_hs_q : head[PW-1];
    map_vs = empty ? last_vs_q : head[PW-2];
    map_de = empty ? 1'b0      : head[PW-3];
    map_r  = empty ? '0        : head[3*CB-1:2*CB];
    map_g  = empty ? '0        : head[2*CB-1:CB];
    map_b  = empty ? '0        : head[CB-1:0];
  end

  lvds_word_map #(
    .CHANNELS   (CHANNELS),
    .COLOR_BITS (COLOR_BITS),
    .MAPPING    (MAPPING)
  ) u_map (
    .hs_i    (map_hs),
    .vs_i    (map_vs),
    .de_i    (map_de),
    .r_i     (map_r),
    .g_i     (map_g),
    .b_i     (map_b),
    .lanes_o (lanes)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= {in_hsync, in_vsync, in_de, in_red, in_green, in_blue};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      slot_q       <= LAST_SLOT;
      sh_q         <= '0;
      clk_sh_q     <= '0;
      word_start_q <= 1'b0;
      underflow_q  <= 1'b0;
      uf_cnt_q     <= '0;
      last_hs_q    <= 1'b0;
      last_vs_q    <= 1'b0;
    end else begin
      slot_q       <= load ? 3'd0 : slot_q + 3'd1;
      word_start_q <= load;
      underflow_q  <= load && enable && empty;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

      if (load) begin
        if (!enable) begin
          sh_q     <= '0;
          clk_sh_q <= '0;
        end else begin
          sh_q     <= lanes;
          clk_sh_q <= CLK_PATTERN;
          if (empty) begin
            if (uf_cnt_q != '1) begin
              uf_cnt_q <= uf_cnt_q + 1'b1;
            end
          end else begin
            last_hs_q <= head[PW-1];
            last_vs_q <= head[PW-2];
          end
        end
      end else begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          sh_q[i] <= {sh_q[i][5:0], 1'b0};
        end
        clk_sh_q <= {clk_sh_q[5:0], 1'b0};
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      out_data[i] = sh_q[i][6];
    end
  end

  assign out_clk         = clk_sh_q[6];
  assign word_start      = word_start_q;
  assign underflow       = underflow_q;
  assign underflow_count = uf_cnt_q;

endmodule

// File: tb/tb_lvds_tx_packer.sv
// Directed bench: an 18-bit instance (3-bit counter) plus 24-bit JEIDA/VESA instances.
module tb_lvds_tx_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 18-bit instance
  logic       en_a = 1'b0, val_a = 1'b0, rdy_a;
  logic       hs_a = 1'b0, vs_a = 1'b0, de_a = 1'b0;
  logic [5:0] r_a = '0, g_a = '0, b_a = '0;
  logic [2:0] dat_a;
  logic       oclk_a, ws_a, uf_a;
  logic [2:0] cnt_a;

  // 24-bit instances share their stimulus
  logic       en_w = 1'b1, val_w = 1'b1;
  logic [7:0] r_w = 8'h81, g_w = 8'h00, b_w = 8'h00;
  logic       rdy_b, rdy_c, oclk_b, oclk_c, ws_b, ws_c, uf_b, uf_c;
  logic [3:0] dat_b, dat_c;
  logic [15:0] cnt_b, cnt_c;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] wa [3];
  logic [6:0] wb [4];
  logic [6:0] wc [4];
  logic [6:0] wclk;
  logic       uf0, uf1, ufb0;

  always #5 clk = ~clk;

  lvds_tx_packer #(.CHANNELS(3), .COLOR_BITS(6), .MAPPING(0), .CNT_W(3)) u_dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .in_valid(val_a), .in_ready(rdy_a),
    .in_hsync(hs_a), .in_vsync(vs_a), .in_de(de_a),
    .in_red(r_a), .in_green(g_a), .in_blue(b_a),
    .out_data(dat_a), .out_clk(oclk_a), .word_start(ws_a),
    .underflow(uf_a), .underflow_count(cnt_a)
  );

  lvds_tx_packer #(.CHANNELS(4), .COLOR_BITS(8), .MAPPING(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .enable(en_w), .in_valid(val_w), .in_ready(rdy_b),
    .in_hsync(1'b0), .in_vsync(1'b0), .in_de(1'b1),
    .in_red(r_w), .in_green(g_w), .in_blue(b_w),
    .out_data(dat_b), .out_clk(oclk_b), .word_start(ws_b),
    .underflow(uf_b), .underflow_count(cnt_b)
  );

  lvds_tx_packer #(.CHANNELS(4), .COLOR_BITS(8), .MAPPING(0), .CNT_W(16)) u_dut_c (
    .clk(clk), .rst(rst), .enable(en_w), .in_valid(val_w), .in_ready(rdy_c),
    .in_hsync(1'b0), .in_vsync(1'b0), .in_de(1'b1),
    .in_red(r_w), .in_green(g_w), .in_blue(b_w),
    .out_data(dat_c), .out_clk(oclk_c), .word_start(ws_c),
    .underflow(uf_c), .underflow_count(cnt_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] red_of(input logic [6:0] c0);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = c0[6-i];
    return r;
  endfunction

  // Slot counters of all instances share rst and free-run, so they stay aligned.
  // Disables instance A after sampling slot dis_at (-1: never).
  task automatic capture_word(input int dis_at);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ws_a) found = 1;
    end
    if (!found) check_eq("word_start_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      for (int ch = 0; ch < 3; ch++) wa[ch][6-k] = dat_a[ch];
      for (int ch = 0; ch < 4; ch++) begin
        wb[ch][6-k] = dat_b[ch];
        wc[ch][6-k] = dat_c[ch];
      end
      wclk[6-k] = oclk_a;
      if (k == 0) begin uf0 = uf_a; ufb0 = uf_b; end
      if (k == 1) uf1 = uf_a;
      if (k == dis_at) en_a = 1'b0;
    end
  endtask

  task automatic do_reset();
    en_a  = 1'b0;
    val_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_pix_a(input logic hs, input logic vs, input logic [5:0] r,
                           input logic [5:0] g, input logic [5:0] b);
    hs_a = hs; vs_a = vs; de_a = 1'b1; r_a = r; g_a = g; b_a = b;
  endtask

  int  seq, win;
  bit  low_seen;
  logic [5:0] prev_red;

  initial begin
    // Reset state
    #12;
    check_eq("rst_data_a", 32'(dat_a), 32'd0);
    check_eq("rst_clk_a", 32'(oclk_a), 32'd0);
    check_eq("rst_ws_a", 32'(ws_a), 32'd0);
    check_eq("rst_uf_a", 32'(uf_a), 32'd0);
    check_eq("rst_cnt_a", 32'(cnt_a), 32'd0);
    check_eq("rst_data_b", 32'(dat_b), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check_eq("ready_after_rst", 32'(rdy_a), 32'd1);

    // 24-bit JEIDA / VESA, R=8'h81: first word is blanking, second is the pixel
    capture_word(-1);
    check_eq("b_first_uf", 32'(ufb0), 32'd1);
    capture_word(-1);
    check_eq("jeida_ch0", 32'(wb[0]), 32'b0000010);
    check_eq("jeida_ch1", 32'(wb[1]), 32'b0000000);
    check_eq("jeida_ch2", 32'(wb[2]), 32'b0000001);
    check_eq("jeida_ch3", 32'(wb[3]), 32'b1000000);
    check_eq("vesa_ch0", 32'(wc[0]), 32'b1000000);
    check_eq("vesa_ch1", 32'(wc[1]), 32'b0000000);
    check_eq("vesa_ch2", 32'(wc[2]), 32'b0000001);
    check_eq("vesa_ch3", 32'(wc[3]), 32'b0100000);
    check_eq("b_cnt", 32'(cnt_b), 32'd1);
    check_eq("c_cnt", 32'(cnt_c), 32'd1);
    check_eq("b_ready_full", 32'(rdy_b), 32'd0);
    check_eq("c_ready_full", 32'(rdy_c), 32'd0);

    // 18-bit continuous stream
    set_pix_a(1'b1, 1'b0, 6'h2A, 6'h15, 6'h3F);
    val_a = 1'b1;
    repeat (3) @(negedge clk);
    en_a = 1'b1;
    for (int w = 0; w < 2; w++) begin
      capture_word(-1);
      check_eq("t1_ch0", 32'(wa[0]), 32'b0101011);
      check_eq("t1_ch1", 32'(wa[1]), 32'b0101011);
      check_eq("t1_ch2", 32'(wa[2]), 32'b1111101);
      check_eq("t1_clk", 32'(wclk), 32'b1100011);
    end
    check_eq("t1_cnt", 32'(cnt_a), 32'd0);

    // Underflow: one word with HS=VS=1, then starve
    do_reset();
    set_pix_a(1'b1, 1'b1, 6'h2A, 6'h15, 6'h3F);
    val_a = 1'b1;
    @(negedge clk);
    val_a = 1'b0;
    en_a  = 1'b1;
    capture_word(-1);
    check_eq("t3_real_ch2", 32'(wa[2]), 32'b1111111);
    check_eq("t3_real_uf", 32'(uf0), 32'd0);
    capture_word(-1);
    check_eq("t3_blank_ch0", 32'(wa[0]), 32'd0);
    check_eq("t3_blank_ch1", 32'(wa[1]), 32'd0);
    check_eq("t3_blank_ch2", 32'(wa[2]), 32'b0000110);
    check_eq("t3_blank_clk", 32'(wclk), 32'b1100011);
    check_eq("t3_uf_slot0", 32'(uf0), 32'd1);
    check_eq("t3_uf_slot1", 32'(uf1), 32'd0);
    check_eq("t3_cnt1", 32'(cnt_a), 32'd1);
    repeat (8) capture_word(-1);
    check_eq("t3_cnt_sat", 32'(cnt_a), 32'd7);
    capture_word(-1);
    check_eq("t3_cnt_hold", 32'(cnt_a), 32'd7);
    check_eq("t3_blank_sync", 32'(wa[2]), 32'b0000110);

    // Back-pressure with sequence numbers in the red field
    seq = 0; win = 0; low_seen = 0;
    fork
      begin
        for (int cyc = 0; cyc < 100; cyc++) begin
          bit acc;
          @(negedge clk);
          set_pix_a(1'b0, 1'b0, seq[5:0], 6'h00, 6'h00);
          val_a = 1'b1;
          acc = rdy_a;
          if (!rdy_a) low_seen = 1;
          @(posedge clk);
          if (acc) begin
            seq++;
            if (cyc >= 20 && cyc < 90) win++;
          end
        end
        @(negedge clk);
        val_a = 1'b0;
      end
      begin
        bit got_real = 0;
        for (int i = 0; i < 4 && !got_real; i++) begin
          capture_word(-1);
          if (wa[2][0]) got_real = 1;
        end
        check_eq("t4_first_real", 32'(got_real), 32'd1);
        check_eq("t4_first_seq", 32'(red_of(wa[0])), 32'd0);
        prev_red = red_of(wa[0]);
        for (int i = 0; i < 7; i++) begin
          capture_word(-1);
          check_eq("t4_seq", 32'(red_of(wa[0])), 32'(prev_red + 6'd1));
          prev_red = prev_red + 6'd1;
        end
      end
    join
    check_eq("t4_ready_low", 32'(low_seen), 32'd1);
    check_eq("t4_accepts_70", 32'(win), 32'd10);

    // Enable dropped mid-word, then restored
    do_reset();
    set_pix_a(1'b0, 1'b0, 6'h11, 6'h00, 6'h00);
    val_a = 1'b1;
    @(negedge clk);
    r_a = 6'h22;
    @(negedge clk);
    val_a = 1'b0;
    en_a  = 1'b1;
    capture_word(3);
    check_eq("t5_inflight_red", 32'(red_of(wa[0])), 32'h11);
    check_eq("t5_inflight_clk", 32'(wclk), 32'b1100011);
    capture_word(-1);
    check_eq("t5_off_data", 32'({wa[0], wa[1], wa[2]}), 32'd0);
    check_eq("t5_off_clk", 32'(wclk), 32'd0);
    check_eq("t5_no_uf", 32'(cnt_a), 32'd0);
    check_eq("t5_one_buffered", 32'(rdy_a), 32'd1);
    en_a = 1'b1;
    capture_word(-1);
    check_eq("t5_resume_red", 32'(red_of(wa[0])), 32'h22);
    check_eq("t5_resume_de", 32'(wa[2][0]), 32'd1);

    // Reset asserted at slot 3 of a real word
    set_pix_a(1'b1, 1'b0, 6'h2A, 6'h15, 6'h3F);
    val_a = 1'b1;
    repeat (2) capture_word(-1);
    begin
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (ws_a) found = 1;
      end
      check_eq("t6_ws_seen", 32'(found), 32'd1);
    end
    repeat (3) @(negedge clk);
    check_eq("t6_pre_data", 32'(dat_a), 32'b111);
    rst = 1'b0;
    #1;
    check_eq("t6_data", 32'(dat_a), 32'd0);
    check_eq("t6_clk", 32'(oclk_a), 32'd0);
    check_eq("t6_ws", 32'(ws_a), 32'd0);
    check_eq("t6_uf", 32'(uf_a), 32'd0);
    check_eq("t6_cnt", 32'(cnt_a), 32'd0);
    val_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_ws_after", 32'(ws_a), 32'd1);
    check_eq("t6_uf_after", 32'(uf_a), 32'd1);
    check_eq("t6_cnt_after", 32'(cnt_a), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
